spi_peripheral_gen: RTL and testbench

Parametrised SPI peripheral (target) with an SPI bus port and a system-side valid/ready interface. It is the generalised successor of the fixed 8-bit device. The block supports any word width, runtime CPOL/CPHA selection, back-to-back words within one CS frame, and CS-abort detection. All SPI pins are oversampled in the clk domain.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_edge_sync.sv | 29 ++
 rtl/spi_peripheral_gen.sv | 172 +++++++++++++++++
 tb/tb_spi_peripheral_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state/mode types and edge-role helper for the SPI peripheral
package spi_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} spi_dev_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  function automatic logic is_sample_edge(input spi_mode_t mode, input logic rise,
                                          input logic fall);
    logic lead;
    logic trail;
    lead  = mode.cpol ? fall : rise;
    trail = mode.cpol ? rise : fall;
    return mode.cpha ? trail : lead;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// rtl/spi_edge_sync.sv - SYNC_STAGES-deep synchroniser with rise/fall pulses on the synced value
module spi_edge_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_peripheral_gen.sv
// rtl/spi_peripheral_gen.sv - parametrised SPI target with oversampled pins and a valid/ready side
// Define SPI_PERIPHERAL_LSB_FIRST_EN to shift and receive LSB first.
module spi_peripheral_gen
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  incomplete,
  output logic                  tx_underrun,
  input  logic                  sck,
  input  logic                  cs_n,
  input  logic                  si,
  output logic                  so,
  output logic                  so_highz
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] si_sync_q;
  logic si_s, sample_edge, sample_cap, shift_edge;

  spi_dev_state_t state_q;
  spi_mode_t      mode_q;
  logic [DATA_WIDTH-1:0] hold_q, shift_q, shift_nxt, load_word;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d, rx_data_q;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic hold_full_q, first_q, urun_pend_q, rx_valid_q, busy_q;
  logic incomplete_q, underrun_q, so_highz_q;

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst(rst), .d_i(sck), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .d_i(cs_n), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) si_sync_q <= '0;
    else     si_sync_q <= {si_sync_q[SYNC_STAGES-2:0], si};
  end

  assign si_s        = si_sync_q[SYNC_STAGES-1];
  assign sample_edge = is_sample_edge(mode_q, sck_rise, sck_fall);
  assign sample_cap  = sample_edge && (bit_cnt_q != CNT_FULL);
  assign shift_edge  = (sck_rise | sck_fall) & ~sample_edge;
  assign load_word   = hold_full_q ? hold_q : '1;
  assign bit_cnt_d   = sample_cap ? bit_cnt_q + CNT_ONE : bit_cnt_q;

`ifdef SPI_PERIPHERAL_LSB_FIRST_EN
  assign rx_shift_d = sample_cap ? {si_s, rx_shift_q[DATA_WIDTH-1:1]} : rx_shift_q;
  assign shift_nxt  = shift_q >> 1;
  assign so         = shift_q[0];
`else
  assign rx_shift_d = sample_cap ? {rx_shift_q[DATA_WIDTH-2:0], si_s} : rx_shift_q;
  assign shift_nxt  = shift_q << 1;
  assign so         = shift_q[DATA_WIDTH-1];
`endif

  // A mid-frame reload with an empty holding register only counts as an underrun once the
  // master actually clocks that word; a reload the frame ends on is never transmitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mode_q       <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      shift_q      <= '0;
      rx_shift_q   <= '0;
      rx_data_q    <= '0;
      bit_cnt_q    <= '0;
      first_q      <= 1'b0;
      urun_pend_q  <= 1'b0;
      rx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      incomplete_q <= 1'b0;
      underrun_q   <= 1'b0;
      so_highz_q   <= 1'b1;
    end else begin
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      if (tx_valid && !hold_full_q) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          so_highz_q <= 1'b1;
          if (cs_fall) begin
            mode_q       <= '{cpol: cpol, cpha: cpha};
            busy_q       <= 1'b1;
            incomplete_q <= 1'b0;
            state_q      <= LOAD;
          end
        end
        LOAD: begin
          if (cs_rise) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            so_highz_q <= 1'b1;
          end else begin
            shift_q     <= load_word;
            if (hold_full_q) hold_full_q <= 1'b0;
            underrun_q  <= ~hold_full_q;
            urun_pend_q <= 1'b0;
            bit_cnt_q   <= '0;
            first_q     <= 1'b1;
            so_highz_q  <= 1'b0;
            state_q     <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            so_highz_q  <= 1'b1;
            bit_cnt_q   <= '0;
            urun_pend_q <= 1'b0;
            if (bit_cnt_d == CNT_FULL) begin
              rx_data_q  <= rx_shift_d;
              rx_valid_q <= 1'b1;
            end else if (bit_cnt_d != '0) begin
              incomplete_q <= 1'b1;
            end
          end else if (bit_cnt_q == CNT_FULL) begin
            rx_data_q   <= rx_shift_q;
            rx_valid_q  <= 1'b1;
            shift_q     <= load_word;
            if (hold_full_q) hold_full_q <= 1'b0;
            urun_pend_q <= ~hold_full_q;
            bit_cnt_q   <= '0;
            first_q     <= 1'b1;
          end else if (sample_cap) begin
            rx_shift_q  <= rx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            first_q     <= 1'b0;
            underrun_q  <= urun_pend_q;
            urun_pend_q <= 1'b0;
          end else if (shift_edge) begin
            // The first drive edge of a word only presents the freshly loaded MSB.
            if (first_q) first_q <= 1'b0;
            else         shift_q <= shift_nxt;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = busy_q;
  assign incomplete  = incomplete_q;
  assign tx_underrun = underrun_q;
  assign so_highz    = so_highz_q;

endmodule

// File: tb/tb_spi_peripheral_gen.sv
// tb/tb_spi_peripheral_gen.sv - directed table-driven bench for spi_peripheral_gen (8- and 16-bit)
module tb_spi_peripheral_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic cpol = 1'b0, cpha = 1'b0, sck = 1'b0, si = 1'b0;
  logic cs8_n = 1'b1, cs16_n = 1'b1;

  logic [7:0]  tx_data8 = '0, rx_data8;
  logic        tx_valid8 = 1'b0, tx_ready8, rx_valid8, busy8, incomplete8, tx_underrun8, so8, so_highz8;
  logic [15:0] tx_data16 = '0, rx_data16;
  logic        tx_valid16 = 1'b0, tx_ready16, rx_valid16, busy16, incomplete16, tx_underrun16, so16, so_highz16;

  spi_peripheral_gen #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha),
    .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(tx_ready8),
    .rx_data(rx_data8), .rx_valid(rx_valid8), .busy(busy8), .incomplete(incomplete8),
    .tx_underrun(tx_underrun8), .sck(sck), .cs_n(cs8_n), .si(si), .so(so8), .so_highz(so_highz8)
  );

  spi_peripheral_gen #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut16 (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha),
    .tx_data(tx_data16), .tx_valid(tx_valid16), .tx_ready(tx_ready16),
    .rx_data(rx_data16), .rx_valid(rx_valid16), .busy(busy16), .incomplete(incomplete16),
    .tx_underrun(tx_underrun16), .sck(sck), .cs_n(cs16_n), .si(si), .so(so16), .so_highz(so_highz16)
  );

  int n_chk = 0;
  int n_pass = 0;

  int          rx_cnt8 = 0, rx_cnt16 = 0, ur_cnt8 = 0, ur_cnt16 = 0;
  logic [7:0]  rx_last8 = '0;
  logic [15:0] rx_q16[$];

  always @(negedge clk) begin
    if (rx_valid8) begin rx_cnt8++; rx_last8 = rx_data8; end
    if (rx_valid16) begin rx_cnt16++; rx_q16.push_back(rx_data16); end
    if (tx_underrun8) ur_cnt8++;
    if (tx_underrun16) ur_cnt16++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input logic s16, input logic [15:0] d);
    int n;
    n = 0;
    while (!(s16 ? tx_ready16 : tx_ready8) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", 32'(s16 ? tx_ready16 : tx_ready8), 32'd1);
    if (s16) begin tx_data16 = d; tx_valid16 = 1'b1; end
    else begin tx_data8 = d[7:0]; tx_valid8 = 1'b1; end
    @(negedge clk);
    tx_valid8 = 1'b0;
    tx_valid16 = 1'b0;
    check("push_taken", 32'(s16 ? tx_ready16 : tx_ready8), 32'd0);
  endtask

  task automatic frame_start(input logic s16, input logic pol, input logic pha);
    cpol = pol;
    cpha = pha;
    sck  = pol;
    repeat (4) @(negedge clk);
    if (s16) cs16_n = 1'b0;
    else cs8_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (4) @(negedge clk);
    cs8_n  = 1'b1;
    cs16_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Master side: half sck period = 4 clk cycles; MISO read at the master's sample edge.
  task automatic xfer(input logic s16, input logic pol, input logic pha, input logic [15:0] mosi,
                      input int width, input int nbits, output logic [15:0] miso);
    miso = '0;
    for (int i = 0; i < nbits; i++) begin
      int b;
      b = width - 1 - i;
      if (!pha) begin
        si = mosi[b];
        repeat (4) @(negedge clk);
        miso[b] = s16 ? so16 : so8;
        sck = ~pol;
        repeat (4) @(negedge clk);
        sck = pol;
      end else begin
        sck = ~pol;
        si  = mosi[b];
        repeat (4) @(negedge clk);
        miso[b] = s16 ? so16 : so8;
        sck = pol;
        repeat (4) @(negedge clk);
      end
    end
  endtask

  typedef struct {
    logic       pol;
    logic       pha;
    logic       push;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    int         exp_ur;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected run to complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] m0, m1, m;
    int rc0, ur0;

    vecs[0] = '{1'b0, 1'b0, 1'b1, 8'h3C, 8'hA5, 8'h3C, 0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 8'h3C, 8'hA5, 8'h3C, 0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 8'h96, 8'h4B, 8'h96, 0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 8'h01, 8'hFE, 8'h01, 0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h81, 8'hFF, 1};

    repeat (3) @(negedge clk);
    check("rst_tx_ready", 32'(tx_ready8), 32'd1);
    check("rst_rx_data", 32'(rx_data8), 32'd0);
    check("rst_rx_valid", 32'(rx_valid8), 32'd0);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_incomplete", 32'(incomplete8), 32'd0);
    check("rst_underrun", 32'(tx_underrun8), 32'd0);
    check("rst_so", 32'(so8), 32'd0);
    check("rst_so_highz", 32'(so_highz8), 32'd1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int k = 0; k < 5; k++) begin
      rc0 = rx_cnt8;
      ur0 = ur_cnt8;
      if (vecs[k].push) push(1'b0, {8'h00, vecs[k].tx});
      frame_start(1'b0, vecs[k].pol, vecs[k].pha);
      check($sformatf("v%0d_busy_in", k), 32'(busy8), 32'd1);
      check($sformatf("v%0d_highz_in", k), 32'(so_highz8), 32'd0);
      xfer(1'b0, vecs[k].pol, vecs[k].pha, {8'h00, vecs[k].mosi}, 8, 8, m);
      frame_end();
      check($sformatf("v%0d_rx_pulses", k), 32'(rx_cnt8 - rc0), 32'd1);
      check($sformatf("v%0d_rx_data", k), 32'(rx_last8), 32'(vecs[k].mosi));
      check($sformatf("v%0d_miso", k), 32'(m[7:0]), 32'(vecs[k].exp_miso));
      check($sformatf("v%0d_underrun", k), 32'(ur_cnt8 - ur0), 32'(vecs[k].exp_ur));
      check($sformatf("v%0d_incomplete", k), 32'(incomplete8), 32'd0);
      check($sformatf("v%0d_busy_out", k), 32'(busy8), 32'd0);
      check($sformatf("v%0d_highz_out", k), 32'(so_highz8), 32'd1);
    end

    // Two back-to-back 16-bit words in one frame, second TX word pushed mid-word.
    push(1'b1, 16'hCAFE);
    frame_start(1'b1, 1'b0, 1'b0);
    fork
      xfer(1'b1, 1'b0, 1'b0, 16'h1234, 16, 16, m0);
      begin
        repeat (20) @(negedge clk);
        push(1'b1, 16'h0F0F);
      end
    join
    xfer(1'b1, 1'b0, 1'b0, 16'hBEEF, 16, 16, m1);
    frame_end();
    check("w16_rx_pulses", 32'(rx_cnt16), 32'd2);
    check("w16_rx0", 32'(rx_q16.size() > 0 ? rx_q16[0] : 16'h0), 32'h1234);
    check("w16_rx1", 32'(rx_q16.size() > 1 ? rx_q16[1] : 16'h0), 32'hBEEF);
    check("w16_miso0", 32'(m0), 32'hCAFE);
    check("w16_miso1", 32'(m1), 32'h0F0F);
    check("w16_underrun", 32'(ur_cnt16), 32'd0);

    // CS abort after three sample edges.
    rc0 = rx_cnt8;
    frame_start(1'b0, 1'b0, 1'b0);
    xfer(1'b0, 1'b0, 1'b0, 16'h00B7, 8, 3, m);
    frame_end();
    check("abort_no_rx", 32'(rx_cnt8 - rc0), 32'd0);
    check("abort_incomplete", 32'(incomplete8), 32'd1);
    check("abort_busy", 32'(busy8), 32'd0);
    frame_start(1'b0, 1'b0, 1'b0);
    check("abort_cleared", 32'(incomplete8), 32'd0);
    xfer(1'b0, 1'b0, 1'b0, 16'h006E, 8, 8, m);
    frame_end();
    check("abort_next_rx", 32'(rx_last8), 32'h6E);

    // Asynchronous reset mid-word with TX data pending.
    frame_start(1'b0, 1'b0, 1'b0);
    push(1'b0, 16'h0077);
    xfer(1'b0, 1'b0, 1'b0, 16'h00F0, 8, 4, m);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_tx_ready", 32'(tx_ready8), 32'd1);
    check("arst_rx_data", 32'(rx_data8), 32'd0);
    check("arst_rx_valid", 32'(rx_valid8), 32'd0);
    check("arst_busy", 32'(busy8), 32'd0);
    check("arst_incomplete", 32'(incomplete8), 32'd0);
    check("arst_underrun", 32'(tx_underrun8), 32'd0);
    check("arst_so", 32'(so8), 32'd0);
    check("arst_so_highz", 32'(so_highz8), 32'd1);
    cs8_n = 1'b1;
    sck   = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    rc0 = rx_cnt8;
    ur0 = ur_cnt8;
    frame_start(1'b0, 1'b0, 1'b0);
    xfer(1'b0, 1'b0, 1'b0, 16'h005A, 8, 8, m);
    frame_end();
    check("post_rst_rx_pulses", 32'(rx_cnt8 - rc0), 32'd1);
    check("post_rst_rx_data", 32'(rx_last8), 32'h5A);
    check("post_rst_miso", 32'(m[7:0]), 32'hFF);
    check("post_rst_underrun", 32'(ur_cnt8 - ur0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
